result_queues_stage: RTL and testbench
======================================

Name: result_queues_stage

Overview:
- Write-side counterpart of the lane operand queues: collects results produced by the lane's functional units and funnels them into the single VRF write port.
- Sources are ALU, MFPU, VLDU, SLDU and MASKU.
- Each source gets a small elastic FIFO. A round-robin arbiter drains the FIFOs toward the VRF, holding a request stable while the VRF stalls it, e.g. on a bank conflict.
- Sits between the VFUs and the VRF write interface in each lane.

Parameters:
- NrSrc, 5, number of result sources (index 0 ALU, 1 MFPU, 2 VLDU, 3 SLDU, 4 MASKU).
- BufDepth, 2, entries per source FIFO (>=1).
- AddrWidth, 10, VRF word address width.
- DataWidth, 64, result word width (ELEN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- result_req_i  in  NrSrc  per-source valid.
- result_addr_i  in  NrSrc*AddrWidth  per-source VRF word address.
- result_wdata_i  in  NrSrc*DataWidth  per-source write data.
- result_be_i  in  NrSrc*(DataWidth/8)  per-source byte enables.
- result_gnt_o  out  NrSrc  per-source accept.
- vrf_req_o  out  1  write request to VRF.
- vrf_addr_o  out  AddrWidth  write address.
- vrf_wdata_o  out  DataWidth  write data.
- vrf_be_o  out  DataWidth/8  write byte enables.
- vrf_src_o  out  $clog2(NrSrc)  index of the source being written.
- vrf_gnt_i  in  1  VRF accepts the write this cycle.
- result_wdone_o  out  NrSrc  one-hot pulse; the source's word was committed to the VRF.

Behaviour:
- Reset (rst_i sampled high at clk_i edge):
  - All FIFOs empty.
  - vrf_req_o=0; vrf_addr_o, vrf_wdata_o, vrf_be_o and vrf_src_o=0.
  - result_wdone_o=0; result_gnt_o=all ones.
  - Round-robin pointer = NrSrc-1, so source 0 has first priority.
  - Lock flag cleared.
  - A reset mid-transfer discards all buffered entries. No wdone pulse is issued for discarded entries.
- Source accept:
  - result_gnt_o[i] = !full[i], purely registered state; it does not depend on the same-cycle pop.
  - Push occurs when result_req_i[i] && result_gnt_o[i].
  - Sources must hold addr/wdata/be stable while req=1 and gnt=0.
- FIFO:
  - Per-source occupancy counter 0..BufDepth, with read and write pointers wrapping modulo BufDepth.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Push when full cannot occur because gnt=0.
  - Data enters the FIFO on the push edge and is visible at the head on the next cycle.
- Arbiter:
  - States are IDLE and LOCKED.
  - IDLE: winner is the first non-empty source searching from pointer+1 upward, wrapping modulo NrSrc. The winner's head drives the vrf_* outputs combinationally; vrf_req_o=1 if any source is non-empty.
  - IDLE, vrf_gnt_i=1 in the same cycle: pop the winner, pointer<=winner, stay IDLE.
  - IDLE, vrf_gnt_i=0: latch winner index, go to LOCKED.
  - LOCKED: vrf_* outputs driven from the latched source's head. These must not change until granted, regardless of new arrivals on higher-priority sources.
  - LOCKED, vrf_gnt_i=1: pop the latched source, pointer<=latched, go to IDLE.
  - vrf_gnt_i with vrf_req_o=0 is ignored.
- Latency:
  - A result pushed at edge N, with the port free and no competitors, produces vrf_req_o=1 during cycle N+1.
  - Sustained throughput is one write per cycle while vrf_gnt_i=1.
- Completion signalling:
  - result_wdone_o[k] is a registered one-cycle pulse in the cycle after the VRF handshake of source k.
  - At most one bit is set per cycle.
- Fairness:
  - A continuously requesting source waits at most NrSrc-1 grants.
  - Order is preserved within a source (FIFO order); no ordering is guaranteed across sources.
- Widths:
  - Pointer and vrf_src_o are $clog2(NrSrc) bits; wrap is explicit, since NrSrc need not be a power of two.
- Assertions:
  - No push when full; no pop when empty.
  - vrf_* outputs stable while vrf_req_o && !vrf_gnt_i.
  - $onehot0(result_wdone_o).

Test Plan:
- After reset, single ALU push (addr=0x012, wdata=0xDEAD_BEEF_0000_0001, be=0xFF) with vrf_gnt_i=1 -> vrf_req_o=1 in the next cycle with matching fields and vrf_src_o=0; result_wdone_o=5'b00001 one cycle later; FIFO empty.
- All 5 sources push one word in the same cycle, vrf_gnt_i=1 -> writes issue in src order 0,1,2,3,4 on 5 consecutive cycles; pointer ends at 4.
- MFPU pushes 3 words back-to-back with vrf_gnt_i=0 -> gnt[1] drops after the 2nd push, 3rd word held; raising vrf_gnt_i drains words in push order and gnt[1] reasserts.
- SLDU requesting, vrf_gnt_i=0 for 4 cycles, ALU pushes meanwhile -> vrf_src_o stays 3 with stable addr/data/be until granted; ALU is written next.
- Sources 0 and 2 saturated, vrf_gnt_i=1 continuously -> grants alternate 0,2,0,2; neither source waits more than 1 grant.
- Two entries buffered, rst_i pulsed one cycle -> vrf_req_o=0, gnt all ones, no wdone pulses; fresh push behaves as in the first scenario.

Source files
------------

// File: rtl/result_queues_stage.sv
// ---------------------------------------------------------------------------
// result_queues_stage
//
// This is the write-side funnel of a lane. The results from ALU, MFPU, VLDU,
// SLDU and MASKU go through it to the single VRF write port.
//
// Each source writes into its own small elastic FIFO. A round-robin arbiter
// drains the FIFO heads toward the VRF. If the VRF does not grant a request,
// for example because of a bank conflict, the arbiter locks onto the offered
// source. The vrf_* outputs then stay frozen until the VRF grants them.
//
// Ports
//   clk_i, rst_i     clock and synchronous active-high reset
//   result_req_i     per-source valid
//   result_addr_i    per-source VRF word address (packed, source 0 in LSBs)
//   result_wdata_i   per-source write data       (packed)
//   result_be_i      per-source byte enables     (packed)
//   result_gnt_o     per-source accept (FIFO not full)
//   vrf_req_o        write request to the VRF
//   vrf_addr_o       write address
//   vrf_wdata_o      write data
//   vrf_be_o         write byte enables
//   vrf_src_o        index of the source being offered
//   vrf_gnt_i        the VRF accepts the write this cycle
//   result_wdone_o   one-hot pulse, the cycle after a source's word commits
// ---------------------------------------------------------------------------
module result_queues_stage #(
    parameter int NrSrc     = 5,
    parameter int BufDepth  = 2,
    parameter int AddrWidth = 10,
    parameter int DataWidth = 64,
    localparam int SrcW     = (NrSrc > 1) ? $clog2(NrSrc) : 1,
    localparam int BeW      = DataWidth / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NrSrc-1:0]           result_req_i,
    input  logic [NrSrc*AddrWidth-1:0] result_addr_i,
    input  logic [NrSrc*DataWidth-1:0] result_wdata_i,
    input  logic [NrSrc*BeW-1:0]       result_be_i,
    output logic [NrSrc-1:0]           result_gnt_o,
    output logic                       vrf_req_o,
    output logic [AddrWidth-1:0]       vrf_addr_o,
    output logic [DataWidth-1:0]       vrf_wdata_o,
    output logic [BeW-1:0]             vrf_be_o,
    output logic [SrcW-1:0]            vrf_src_o,
    input  logic                       vrf_gnt_i,
    output logic [NrSrc-1:0]           result_wdone_o
);

    localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int CntW = $clog2(BufDepth + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Per-source FIFO status and head words.
    logic [NrSrc-1:0]                full;
    logic [NrSrc-1:0]                empty;
    logic [NrSrc-1:0]                push;
    logic [NrSrc-1:0]                pop;
    logic [NrSrc-1:0][AddrWidth-1:0] head_addr;
    logic [NrSrc-1:0][DataWidth-1:0] head_wdata;
    logic [NrSrc-1:0][BeW-1:0]       head_be;

    // Arbiter state.
    logic [0:0]       state_reg;
    logic [SrcW-1:0]  lock_src_reg;
    logic [SrcW-1:0]  rr_ptr_reg;
    logic [NrSrc-1:0] wdone_reg;

    logic [SrcW-1:0]  winner;
    logic             any_valid;
    logic [SrcW-1:0]  sel_src;
    logic             handshake;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Per-source elastic FIFOs
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NrSrc; gi++) begin : g_fifo
            logic [AddrWidth-1:0] addr_mem  [BufDepth];
            logic [DataWidth-1:0] wdata_mem [BufDepth];
            logic [BeW-1:0]       be_mem    [BufDepth];
            logic [PtrW-1:0]      wr_ptr_reg;
            logic [PtrW-1:0]      rd_ptr_reg;
            logic [CntW-1:0]      count_reg;

            assign full[gi]  = (count_reg == CntW'(BufDepth));
            assign empty[gi] = (count_reg == '0);

            // The accept depends only on registered occupancy. A pop in the
            // same cycle does not free a slot for a push in that cycle.
            assign result_gnt_o[gi] = !full[gi];
            assign push[gi] = result_req_i[gi] && !full[gi];
            assign pop[gi]  = handshake && (sel_src == SrcW'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    if (pop[gi])  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    if (push[gi] && !pop[gi])
                        count_reg <= count_reg + CntW'(1);
                    else if (!push[gi] && pop[gi])
                        count_reg <= count_reg - CntW'(1);
                end
            end

            // Storage is not reset. Stale words are never offered, because
            // the head is only used while the count is non-zero.
            always_ff @(posedge clk_i) begin
                if (push[gi]) begin
                    addr_mem[wr_ptr_reg]  <= result_addr_i[gi*AddrWidth +: AddrWidth];
                    wdata_mem[wr_ptr_reg] <= result_wdata_i[gi*DataWidth +: DataWidth];
                    be_mem[wr_ptr_reg]    <= result_be_i[gi*BeW +: BeW];
                end
            end

            assign head_addr[gi]  = addr_mem[rd_ptr_reg];
            assign head_wdata[gi] = wdata_mem[rd_ptr_reg];
            assign head_be[gi]    = be_mem[rd_ptr_reg];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin winner. The search starts at the source after the last
    // one served. The wrap is explicit, because NrSrc need not be a power
    // of two.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NrSrc; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NrSrc) idx = idx - NrSrc;
            if (!any_valid && !empty[idx]) begin
                any_valid = 1'b1;
                winner    = SrcW'(idx);
            end
        end
    end

    // While the arbiter is locked, the latched source keeps the port. A
    // higher-priority arrival therefore cannot change the stalled request.
    assign sel_src   = (state_reg == ST_LOCKED) ? lock_src_reg : winner;
    assign vrf_req_o = (state_reg == ST_LOCKED) || any_valid;
    assign handshake = vrf_req_o && vrf_gnt_i;

    assign vrf_src_o   = vrf_req_o ? sel_src : '0;
    assign vrf_addr_o  = vrf_req_o ? head_addr[sel_src]  : '0;
    assign vrf_wdata_o = vrf_req_o ? head_wdata[sel_src] : '0;
    assign vrf_be_o    = vrf_req_o ? head_be[sel_src]    : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            lock_src_reg <= '0;
            rr_ptr_reg   <= SrcW'(NrSrc - 1);
            wdone_reg    <= '0;
        end else begin
            wdone_reg <= pop;
            if (handshake) begin
                rr_ptr_reg <= sel_src;
                state_reg  <= ST_IDLE;
            end else if (state_reg == ST_IDLE && any_valid) begin
                state_reg    <= ST_LOCKED;
                lock_src_reg <= winner;
            end
        end
    end

    assign result_wdone_o = wdone_reg;

    // -----------------------------------------------------------------------
    // Protocol checks
    // -----------------------------------------------------------------------
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (push & full) == '0);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        (pop & empty) == '0);
    a_vrf_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (vrf_req_o && !vrf_gnt_i) |=> (vrf_req_o && $stable(vrf_src_o) &&
        $stable(vrf_addr_o) && $stable(vrf_wdata_o) && $stable(vrf_be_o)));
    a_wdone_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(result_wdone_o));

endmodule

// File: tb/tb_result_queues_stage.sv
// ---------------------------------------------------------------------------
// tb_result_queues_stage
//
// This is a cycle-stepped bench for result_queues_stage. The reference model
// keeps one queue of words per source, a "last served" index and an optional
// "held" source. Each cycle it predicts the accepts, the offered VRF write and
// the completion pulse. The bench then compares these with the DUT on the
// falling edge. The directed scenarios come first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_result_queues_stage;

    localparam int N  = 5;
    localparam int D  = 2;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int SW = $clog2(N);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      result_req_i;
    logic [N*AW-1:0]   result_addr_i;
    logic [N*DW-1:0]   result_wdata_i;
    logic [N*BW-1:0]   result_be_i;
    logic [N-1:0]      result_gnt_o;
    logic              vrf_req_o;
    logic [AW-1:0]     vrf_addr_o;
    logic [DW-1:0]     vrf_wdata_o;
    logic [BW-1:0]     vrf_be_o;
    logic [SW-1:0]     vrf_src_o;
    logic              vrf_gnt_i;
    logic [N-1:0]      result_wdone_o;

    always #5 clk_i = ~clk_i;

    result_queues_stage #(
        .NrSrc     (N),
        .BufDepth  (D),
        .AddrWidth (AW),
        .DataWidth (DW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .result_req_i   (result_req_i),
        .result_addr_i  (result_addr_i),
        .result_wdata_i (result_wdata_i),
        .result_be_i    (result_be_i),
        .result_gnt_o   (result_gnt_o),
        .vrf_req_o      (vrf_req_o),
        .vrf_addr_o     (vrf_addr_o),
        .vrf_wdata_o    (vrf_wdata_o),
        .vrf_be_o       (vrf_be_o),
        .vrf_src_o      (vrf_src_o),
        .vrf_gnt_i      (vrf_gnt_i),
        .result_wdone_o (result_wdone_o)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] b;
    } word_t;

    // Reference model state
    word_t        q [N][$];
    word_t        pend [N];
    int           last_served;
    int           held;
    logic [N-1:0] exp_wdone;
    int           obs_log [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        w.a = AW'($urandom);
        w.d = {$urandom, $urandom};
        w.b = BW'($urandom);
        return w;
    endfunction

    // This is the next source the spec's rules would offer, or -1 if none.
    function automatic int exp_sel();
        if (held >= 0) return held;
        for (int k = 1; k <= N; k++) begin
            int s;
            s = (last_served + k) % N;
            if (q[s].size() != 0) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        last_served = N - 1;
        held        = -1;
        exp_wdone   = '0;
    endtask

    // One clock cycle. It is entered and left on a falling edge.
    task automatic step(input logic [N-1:0] req, input logic vg);
        int           sel;
        logic [N-1:0] egnt;
        sel = exp_sel();
        for (int i = 0; i < N; i++) egnt[i] = (q[i].size() < D);
        chk("gnt", 64'(result_gnt_o), 64'(egnt));
        chk("wdone", 64'(result_wdone_o), 64'(exp_wdone));
        chk("req", 64'(vrf_req_o), 64'(sel >= 0));
        if (sel >= 0) begin
            chk("src", 64'(vrf_src_o), 64'(sel));
            chk("addr", 64'(vrf_addr_o), 64'(q[sel][0].a));
            chk("wdata", vrf_wdata_o, q[sel][0].d);
            chk("be", 64'(vrf_be_o), 64'(q[sel][0].b));
        end
        if (vrf_req_o && vg) obs_log.push_back(int'(vrf_src_o));
        result_req_i = req;
        for (int i = 0; i < N; i++) begin
            result_addr_i[i*AW +: AW]  = pend[i].a;
            result_wdata_i[i*DW +: DW] = pend[i].d;
            result_be_i[i*BW +: BW]    = pend[i].b;
        end
        vrf_gnt_i = vg;
        @(posedge clk_i);
        if (sel >= 0 && vg) begin
            void'(q[sel].pop_front());
            last_served = sel;
            held        = -1;
            exp_wdone   = N'(1) << sel;
        end else begin
            exp_wdone = '0;
            if (sel >= 0) held = sel;
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && egnt[i]) begin
                q[i].push_back(pend[i]);
                pend[i] = rand_word();
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        result_req_i = '0;
        vrf_gnt_i    = 1'b0;
        @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_gnt", 64'(result_gnt_o), 64'(5'b11111));
        chk("rst_req", 64'(vrf_req_o), 64'd0);
        chk("rst_addr", 64'(vrf_addr_o), 64'd0);
        chk("rst_wdata", vrf_wdata_o, 64'd0);
        chk("rst_be", 64'(vrf_be_o), 64'd0);
        chk("rst_src", 64'(vrf_src_o), 64'd0);
        chk("rst_wdone", 64'(result_wdone_o), 64'd0);
    endtask

    task automatic drain();
        for (int c = 0; c < 4 * N * D; c++) step('0, 1'b1);
    endtask

    task automatic alu_single();
        pend[0] = '{a: 10'h012, d: 64'hDEAD_BEEF_0000_0001, b: 8'hFF};
        step(5'b00001, 1'b1);
        chk("s1_req", 64'(vrf_req_o), 64'd1);
        chk("s1_addr", 64'(vrf_addr_o), 64'h012);
        chk("s1_wdata", vrf_wdata_o, 64'hDEAD_BEEF_0000_0001);
        chk("s1_src", 64'(vrf_src_o), 64'd0);
        step('0, 1'b1);
        chk("s1_wdone", 64'(result_wdone_o), 64'b00001);
        step('0, 1'b1);
        chk("s1_empty", 64'(vrf_req_o), 64'd0);
    endtask

    initial begin
        rst_i          = 1'b1;
        result_req_i   = '0;
        result_addr_i  = '0;
        result_wdata_i = '0;
        result_be_i    = '0;
        vrf_gnt_i      = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = rand_word();
        model_reset();
        @(negedge clk_i);
        do_reset();

        // The ALU pushes a single word into an idle stage.
        alu_single();

        // All sources push at once. The writes drain in order 0..4.
        do_reset();
        obs_log.delete();
        step(5'b11111, 1'b1);
        for (int c = 0; c < 6; c++) step('0, 1'b1);
        chk("s2_cnt", 64'(obs_log.size()), 64'd5);
        for (int j = 0; j < 5 && j < obs_log.size(); j++)
            chk("s2_order", 64'(obs_log[j]), 64'(j));

        // The SLDU is stalled and locked while the ALU (now higher
        // priority) arrives.
        obs_log.delete();
        step(5'b01000, 1'b0);
        step(5'b00001, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("s4_hold", 64'(vrf_src_o), 64'd3);
            step('0, 1'b0);
        end
        step('0, 1'b1);
        step('0, 1'b1);
        chk("s4_cnt", 64'(obs_log.size()), 64'd2);
        if (obs_log.size() == 2) begin
            chk("s4_first", 64'(obs_log[0]), 64'd3);
            chk("s4_second", 64'(obs_log[1]), 64'd0);
        end
        drain();

        // The MFPU pushes three words back-to-back with the VRF stalled.
        step(5'b00010, 1'b0);
        step(5'b00010, 1'b0);
        chk("s3_full", 64'(result_gnt_o[1]), 64'd0);
        step(5'b00010, 1'b0);
        step(5'b00010, 1'b1);
        for (int c = 0; c < 4; c++) step('0, 1'b1);
        chk("s3_regnt", 64'(result_gnt_o[1]), 64'd1);

        // Sources 0 and 2 are saturated and the VRF always grants.
        obs_log.delete();
        for (int c = 0; c < 14; c++) step(5'b00101, 1'b1);
        for (int j = 1; j < obs_log.size(); j++)
            chk("s5_alt", 64'(obs_log[j]), 64'(2 - obs_log[j-1]));
        drain();

        // Reset arrives with two entries buffered and the port locked.
        step(5'b00011, 1'b0);
        step('0, 1'b0);
        do_reset();
        step('0, 1'b1);
        alu_single();

        // Randomized traffic.
        for (int c = 0; c < 400; c++)
            step(N'($urandom), ($urandom_range(0, 3) != 0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
